// File: rtl/fp_mul_booth_seq.sv
// -----------------------------------------------------------------------------
// fp_mul_booth_seq
// Sequential radix-4 Booth significand multiplier for the binary32 multiplier.
// It accepts two operands over a valid/ready handshake and unpacks them. It
// retires one Booth digit per cycle (13 digits). It presents the exact 48-bit
// significand product together with sign, biased exponent sum, the captured
// rounding mode and operand class flags. These feed the norm/round stages.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (ready only while idle)
//   fp_X, fp_Y            binary32 operands
//   r_mode                rounding mode, captured and forwarded
//   out_valid / out_ready result handshake (outputs stable while valid)
//   frc_Z_full            {1,frc_X}*{1,frc_Y}, 0 for zero/special operands
//   norm_n                frc_Z_full[47]
//   sign_Z                fp_X[31]^fp_Y[31]
//   exp_sum               two's complement eX+eY-127 (10 bits)
//   r_mode_q              captured r_mode
//   zero_Z                an operand has exponent 0 and neither is special
//   special_Z             an operand has exponent 0xFF
// -----------------------------------------------------------------------------
module fp_mul_booth_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] fp_X,
   input  logic [31:0] fp_Y,
   input  logic [2:0]  r_mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [47:0] frc_Z_full,
   output logic        norm_n,
   output logic        sign_Z,
   output logic [9:0]  exp_sum,
   output logic [2:0]  r_mode_q,
   output logic        zero_Z,
   output logic        special_Z
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [49:0] acc_q, acc_d;        // running signed partial sum (two's complement)
   logic [49:0] mshift_q, mshift_d;  // multiplicand pre-shifted by 2*cnt
   logic [26:0] qx_q, qx_d;          // multiplier with implicit 0 appended below bit 0
   logic [3:0]  cnt_q, cnt_d;
   logic [47:0] frc_q, frc_d;
   logic        sign_q, sign_d;
   logic [9:0]  exp_q, exp_d;
   logic [2:0]  rm_q, rm_d;
   logic        zero_q, zero_d;
   logic        special_q, special_d;

   logic [7:0]  ex_s, ey_s;
   logic        accept_s;
   logic        special_in_s;
   logic        zero_in_s;
   logic [49:0] term_s;
   logic [49:0] acc_sum_s;

   assign ex_s         = fp_X[30:23];
   assign ey_s         = fp_Y[30:23];
   assign accept_s     = in_valid && (state_q == S_IDLE);
   // Special (Inf/NaN) wins over zero/subnormal classification.
   assign special_in_s = (ex_s == 8'hFF) || (ey_s == 8'hFF);
   assign zero_in_s    = ((ex_s == 8'h00) || (ey_s == 8'h00)) && !special_in_s;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: zero/special operands skip the Booth iteration.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               if (zero_in_s || special_in_s) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ITER;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ITER: begin
            if (cnt_q == 4'd12) begin
               state_d = S_DONE;
            end else begin
               state_d = S_ITER;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Handshake outputs decoded from the state register only.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
         end
         S_DONE: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Booth digit from {q[2i+1], q[2i], q[2i-1]}; the shifted window sits in qx_q[2:0].
   always_comb begin
      term_s = 50'd0;
      case (qx_q[2:0])
         3'b001, 3'b010: term_s = mshift_q;
         3'b011:         term_s = {mshift_q[48:0], 1'b0};
         3'b100:         term_s = 50'd0 - {mshift_q[48:0], 1'b0};
         3'b101, 3'b110: term_s = 50'd0 - mshift_q;
         default:        term_s = 50'd0;
      endcase
   end

   assign acc_sum_s = acc_q + term_s;

   // Datapath next-state: capture on accept, accumulate one digit per ITER cycle.
   always_comb begin
      acc_d     = acc_q;
      mshift_d  = mshift_q;
      qx_d      = qx_q;
      cnt_d     = cnt_q;
      frc_d     = frc_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      rm_d      = rm_q;
      zero_d    = zero_q;
      special_d = special_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               sign_d    = fp_X[31] ^ fp_Y[31];
               exp_d     = {2'b00, ex_s} + {2'b00, ey_s} - 10'd127;
               rm_d      = r_mode;
               zero_d    = zero_in_s;
               special_d = special_in_s;
               mshift_d  = {26'd0, 1'b1, fp_X[22:0]};
               qx_d      = {2'b00, 1'b1, fp_Y[22:0], 1'b0};
               acc_d     = 50'd0;
               cnt_d     = 4'd0;
               frc_d     = 48'd0;
            end else begin
               acc_d = acc_q;
            end
         end
         S_ITER: begin
            acc_d    = acc_sum_s;
            mshift_d = {mshift_q[47:0], 2'b00};
            qx_d     = {2'b00, qx_q[26:2]};
            cnt_d    = cnt_q + 4'd1;
            // The last digit leaves the exact, non-negative product in the sum.
            if (cnt_q == 4'd12) begin
               frc_d = acc_sum_s[47:0];
            end else begin
               frc_d = frc_q;
            end
         end
         default: begin
            acc_d = acc_q;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= 50'd0;
         mshift_q  <= 50'd0;
         qx_q      <= 27'd0;
         cnt_q     <= 4'd0;
         frc_q     <= 48'd0;
         sign_q    <= 1'b0;
         exp_q     <= 10'd0;
         rm_q      <= 3'd0;
         zero_q    <= 1'b0;
         special_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         mshift_q  <= mshift_d;
         qx_q      <= qx_d;
         cnt_q     <= cnt_d;
         frc_q     <= frc_d;
         sign_q    <= sign_d;
         exp_q     <= exp_d;
         rm_q      <= rm_d;
         zero_q    <= zero_d;
         special_q <= special_d;
      end
   end

   assign frc_Z_full = frc_q;
   assign norm_n     = frc_q[47];
   assign sign_Z     = sign_q;
   assign exp_sum    = exp_q;
   assign r_mode_q   = rm_q;
   assign zero_Z     = zero_q;
   assign special_Z  = special_q;

endmodule
